dram_responder: RTL and testbench

- Memory-side responder for the accelerator's DRAM interface.
- Serves the accelerator's read requests (DRAMreadEn/DRAMreadAddr) with 64-bit ifmap words after a fixed latency.
- Absorbs the accelerator's write stream (DRAMwriteEn/Addr/Data) into an output store, and detects end of layer and protocol errors.
- Used as the DRAM stand-in for function sim and FPGA bring-up; the host preloads ifmap data and dumps results through a side port.

---
 rtl/dram_responder_if.sv | 24 ++
 rtl/dram_responder.sv | 126 ++++++++++++
 tb/tb_dram_responder.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_responder_if.sv
// Accelerator-side DRAM bus: read request/return and write stream.
interface dram_responder_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
);
    logic              DRAMreadEn;
    logic [ADDR_W-1:0] DRAMreadAddr;
    logic [DATA_W-1:0] ifmap;
    logic              DRAMwriteEn;
    logic [ADDR_W-1:0] DRAMwriteAddr;
    logic [DATA_W-1:0] DRAMwriteData;

    modport master (
        output DRAMreadEn, DRAMreadAddr,
        output DRAMwriteEn, DRAMwriteAddr, DRAMwriteData,
        input  ifmap
    );

    modport slave (
        input  DRAMreadEn, DRAMreadAddr,
        input  DRAMwriteEn, DRAMwriteAddr, DRAMwriteData,
        output ifmap
    );
endinterface

// File: rtl/dram_responder.sv
// DRAM stand-in: serves ifmap reads, absorbs output writes, host load/dump.
// Define DRAM_RESP_CYCLE_CNT_EN to build the run_cycles counter.
module dram_responder #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 64,
    parameter int RD_LAT     = 1,
    parameter int EXP_WRITES = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    dram_responder_if.slave   bus,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   wr_count,
    output logic              err_dup,
    output logic              err_unexp,
    output logic [31:0]       run_cycles
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] EXP = CW'(EXP_WRITES);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic [DATA_W-1:0] ifmap_store [DEPTH];
    logic [DATA_W-1:0] out_store [DEPTH];
    logic [DEPTH-1:0]  written;
    logic [RD_LAT-1:0] rd_v;
    logic [DATA_W-1:0] rd_d [RD_LAT];
    logic [DATA_W-1:0] ifmap_hold;
    logic              in_run;
    logic              launch;
    logic              wr_hit;
    logic              wr_new;
    logic [CW-1:0]     count_inc;

    assign in_run    = state == RUN;
    assign launch    = !in_run && start;
    assign wr_hit    = in_run && bus.DRAMwriteEn;
    assign wr_new    = wr_hit && !written[bus.DRAMwriteAddr];
    assign count_inc = wr_count + CW'(1);
    assign busy      = in_run;
    assign done      = state == DONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_count  <= '0;
            written   <= '0;
            err_dup   <= 1'b0;
            err_unexp <= 1'b0;
        end else if (launch) begin
            state     <= RUN;
            wr_count  <= '0;
            written   <= '0;
            err_dup   <= 1'b0;
            err_unexp <= 1'b0;
        end else if (in_run) begin
            if (wr_new) begin
                written[bus.DRAMwriteAddr] <= 1'b1;
                wr_count <= count_inc;
                if (count_inc == EXP)
                    state <= DONE;
            end else if (wr_hit) begin
                err_dup <= 1'b1;
            end
        end else if (bus.DRAMwriteEn) begin
            err_unexp <= 1'b1;
        end
    end

    // Stores are never reset; host loads are locked out while running.
    always_ff @(posedge clk) begin
        if (!rst && wr_hit)
            out_store[bus.DRAMwriteAddr] <= bus.DRAMwriteData;
        if (!rst && load_en && !in_run)
            ifmap_store[load_addr] <= load_data;
    end

    always_ff @(posedge clk) begin
        if (rst)
            dump_data <= '0;
        else
            dump_data <= out_store[dump_addr];
    end

    // Data is captured at the sampling edge so a same-cycle load is not seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_v       <= '0;
            ifmap_hold <= '0;
            for (int i = 0; i < RD_LAT; i++)
                rd_d[i] <= '0;
        end else begin
            rd_v[0]    <= bus.DRAMreadEn;
            rd_d[0]    <= ifmap_store[bus.DRAMreadAddr];
            for (int i = 1; i < RD_LAT; i++) begin
                rd_v[i] <= rd_v[i-1];
                rd_d[i] <= rd_d[i-1];
            end
            ifmap_hold <= bus.ifmap;
        end
    end

    assign bus.ifmap = rd_v[RD_LAT-1] ? rd_d[RD_LAT-1] : ifmap_hold;

`ifdef DRAM_RESP_CYCLE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || launch)
            run_cycles <= '0;
        else if (in_run && run_cycles != '1)
            run_cycles <= run_cycles + 32'd1;
    end
`else
    assign run_cycles = '0;
`endif
endmodule

// File: tb/tb_dram_responder.sv
// Bench for dram_responder: plan scenarios, then random traffic
// checked every cycle against a behavioural model.
module tb_dram_responder;
    localparam int AW   = 4;
    localparam int DW   = 64;
    localparam int LAT  = 3;
    localparam int EXPW = 4;
    localparam int N    = 1 << AW;
    localparam logic [DW-1:0] W5 = 64'h1122334455667788;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic [AW-1:0] dump_addr;
    logic [DW-1:0] dump_data;
    logic          busy;
    logic          done;
    logic [AW:0]   wr_count;
    logic          err_dup;
    logic          err_unexp;
    logic [31:0]   run_cycles;

    always #5 clk = ~clk;

    dram_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    dram_responder #(
        .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .EXP_WRITES(EXPW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .dump_addr(dump_addr),
        .dump_data(dump_data), .busy(busy), .done(done),
        .wr_count(wr_count), .err_dup(err_dup),
        .err_unexp(err_unexp), .run_cycles(run_cycles)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural model: stores as arrays, read latency as a queue.
    typedef struct packed { logic v; logic [DW-1:0] d; } rd_t;
    rd_t           rq[$];
    logic [DW-1:0] m_if [N];
    logic [DW-1:0] m_out [N];
    bit            m_out_k [N];
    bit            m_wr [N];
    int            m_mode;
    int            m_cnt;
    bit            m_dup;
    bit            m_unexp;
    logic [DW-1:0] e_ifmap;
    logic [DW-1:0] e_dump;
    bit            e_dump_k;
    longint        e_runc;

    task automatic model();
        bit  was_run;
        rd_t e;
        was_run = (m_mode == 1);
        if (rst) begin
            m_mode = 0; m_cnt = 0; m_dup = 0; m_unexp = 0;
            m_wr = '{default: 0};
            rq.delete();
            e_ifmap = '0; e_dump = '0; e_dump_k = 1; e_runc = 0;
            return;
        end
        e.v = bus.DRAMreadEn;
        e.d = m_if[bus.DRAMreadAddr];
        rq.push_back(e);
        if (rq.size() >= LAT) begin
            e = rq.pop_front();
            if (e.v) e_ifmap = e.d;
        end
        e_dump   = m_out[dump_addr];
        e_dump_k = m_out_k[dump_addr];
        if (!was_run && start) begin
            m_mode = 1; m_cnt = 0; m_dup = 0; m_unexp = 0;
            m_wr = '{default: 0};
            e_runc = 0;
        end else if (was_run) begin
            if (e_runc < 64'hFFFF_FFFF) e_runc++;
            if (bus.DRAMwriteEn) begin
                m_out[bus.DRAMwriteAddr]   = bus.DRAMwriteData;
                m_out_k[bus.DRAMwriteAddr] = 1;
                if (m_wr[bus.DRAMwriteAddr]) m_dup = 1;
                else begin
                    m_wr[bus.DRAMwriteAddr] = 1;
                    m_cnt++;
                    if (m_cnt == EXPW) m_mode = 2;
                end
            end
        end else if (bus.DRAMwriteEn) begin
            m_unexp = 1;
        end
        if (!was_run && load_en) m_if[load_addr] = load_data;
    endtask

    task automatic compare_all();
        chk("ifmap", bus.ifmap, e_ifmap);
        if (e_dump_k) chk("dump_data", dump_data, e_dump);
        chk("busy", 64'(busy), 64'(m_mode == 1));
        chk("done", 64'(done), 64'(m_mode == 2));
        chk("wr_count", 64'(wr_count), 64'(m_cnt));
        chk("err_dup", 64'(err_dup), 64'(m_dup));
        chk("err_unexp", 64'(err_unexp), 64'(m_unexp));
`ifdef DRAM_RESP_CYCLE_CNT_EN
        chk("run_cycles", 64'(run_cycles), 64'(e_runc));
`else
        chk("run_cycles", 64'(run_cycles), 64'd0);
`endif
    endtask

    task automatic clear_in();
        rst = 0; start = 0; load_en = 0;
        load_addr = '0; load_data = '0; dump_addr = '0;
        bus.DRAMreadEn = 0; bus.DRAMreadAddr = '0;
        bus.DRAMwriteEn = 0; bus.DRAMwriteAddr = '0;
        bus.DRAMwriteData = '0;
    endtask

    task automatic step();
        @(posedge clk);
        model();
        #1;
        compare_all();
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        clear_in();
        bus.DRAMwriteEn = 1;
        bus.DRAMwriteAddr = AW'(a);
        bus.DRAMwriteData = d;
        step();
    endtask

    task automatic rd(input int a);
        clear_in();
        bus.DRAMreadEn = 1;
        bus.DRAMreadAddr = AW'(a);
        step();
    endtask

    initial begin
        m_out_k = '{default: 0};
        m_wr = '{default: 0};
        clear_in();
        rst = 1;
        step();
        step();
        chk("rst_ifmap", bus.ifmap, 64'd0);
        chk("rst_dump", dump_data, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        for (int a = 0; a < N; a++) begin
            clear_in();
            load_en = 1;
            load_addr = AW'(a);
            load_data = (a == 5) ? W5 : 64'hF0F0_0000_0000_0000 + 64'(a);
            step();
        end

        clear_in(); start = 1; step();
        rd(5);
        rd(6);
        chk("rd_early", bus.ifmap, 64'd0);
        rd(7);
        chk("rd_lat_a5", bus.ifmap, W5);
        clear_in(); step();
        chk("rd_b2b_a6", bus.ifmap, 64'hF0F0_0000_0000_0006);
        step();
        chk("rd_b2b_a7", bus.ifmap, 64'hF0F0_0000_0000_0007);
        step();
        chk("rd_hold", bus.ifmap, 64'hF0F0_0000_0000_0007);

        for (int i = 0; i < 4; i++) begin
            wr(i, 64'hA0 + 64'(i));
            chk("wr_count_seq", 64'(wr_count), 64'(i + 1));
        end
        chk("done_after_4", 64'(done), 64'd1);
        chk("busy_after_4", 64'(busy), 64'd0);
        clear_in(); dump_addr = 2; step();
        chk("dump_a2", dump_data, 64'hA2);

        clear_in(); rst = 1; step();
        wr(3, 64'hFF);
        chk("unexp_set", 64'(err_unexp), 64'd1);
        clear_in(); dump_addr = 3; step();
        chk("dump_a3_kept", dump_data, 64'hA3);
        clear_in(); start = 1; step();
        chk("unexp_cleared", 64'(err_unexp), 64'd0);

        wr(9, 64'h1);
        wr(9, 64'h2);
        chk("dup_count", 64'(wr_count), 64'd1);
        chk("dup_flag", 64'(err_dup), 64'd1);
        clear_in(); dump_addr = 9; step();
        chk("dup_dump", dump_data, 64'h2);

        clear_in(); rst = 1; step();
        clear_in(); start = 1; step();
        wr(10, 64'h10);
        wr(11, 64'h11);
        clear_in(); rst = 1; step();
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_count", 64'(wr_count), 64'd0);
        chk("midrst_dup", 64'(err_dup), 64'd0);
        clear_in(); dump_addr = 10; step();
        chk("midrst_dump", dump_data, 64'h10);

        clear_in(); start = 1; step();
        clear_in();
        load_en = 1; load_addr = 5; load_data = 64'hDEAD;
        step();
        rd(5);
        clear_in(); step(); step();
        chk("load_in_run", bus.ifmap, W5);

        clear_in(); rst = 1; step();
        clear_in(); start = 1; step();
        for (int c = 1; c <= 10; c++) begin
            if (c % 3 == 1) wr(c, 64'(c));
            else begin clear_in(); step(); end
        end
        chk("cnt_done", 64'(done), 64'd1);
        clear_in(); step(); step();
`ifdef DRAM_RESP_CYCLE_CNT_EN
        chk("run_cycles_held", 64'(run_cycles), 64'd10);
`else
        chk("run_cycles_off", 64'(run_cycles), 64'd0);
`endif

        for (int c = 0; c < 3000; c++) begin
            clear_in();
            rst = ($urandom_range(0, 299) == 0);
            start = !rst && ($urandom_range(0, 24) == 0);
            bus.DRAMreadEn = 1'($urandom_range(0, 1));
            bus.DRAMreadAddr = AW'($urandom_range(0, N - 1));
            bus.DRAMwriteEn = !rst && !start && ($urandom_range(0, 9) < 4);
            bus.DRAMwriteAddr = AW'($urandom_range(0, N - 1));
            bus.DRAMwriteData = {$urandom, $urandom};
            load_en = !rst && ($urandom_range(0, 9) < 3);
            load_addr = AW'($urandom_range(0, N - 1));
            load_data = {$urandom, $urandom};
            dump_addr = AW'($urandom_range(0, N - 1));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
